// File: rtl/prog_clk_div_pkg.sv
`default_nettype none
// ============================================================================
// Module  : prog_clk_div_pkg
// Purpose : Shared constants for the programmable clock divider.
//           DIV_W_DEF  - default divisor width in bits
//           DEF_DIV_DEF- divisor in force after reset
//           MIN_DIV    - smallest legal divisor; smaller requests are promoted
// Revision: 1.0 - initial release
// ============================================================================
package prog_clk_div_pkg;
  localparam int DIV_W_DEF   = 8;
  localparam int DEF_DIV_DEF = 5;
  localparam int MIN_DIV     = 2;
endpackage
`default_nettype wire

// File: rtl/prog_clk_div_phase.sv
`default_nettype none
// ============================================================================
// Module  : clk_div_phase
// Purpose : Period counter and phase flops of the divider. Produces a
//           glitch-free divided clock (one AND of two flop outputs) and a
//           tick on the last cycle of every period.
// Ports   : clk_in  - source clock
//           rst     - asynchronous active-low reset
//           run     - divider running (counter advances)
//           n       - active divisor, held stable except at period start
//           clk_out - divided clock
//           tick    - high while cnt == n-1 and running
// Revision: 1.0 - initial release
// ============================================================================
module clk_div_phase
  import prog_clk_div_pkg::*;
#(
  parameter int W = DIV_W_DEF
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         run,
  input  logic [W-1:0] n,
  output logic         clk_out,
  output logic         tick
);

  logic [W-1:0] cnt;
  logic         q_p;
  logic         q_n;
  logic [W:0]   half;
  logic         last;

  // ceil(n/2), one bit wider so n = 2^W-1 does not overflow
  assign half = ({1'b0, n} + (W+1)'(1)) >> 1;
  assign last = (cnt == (n - W'(1)));
  assign tick = run & last;

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      q_p <= 1'b0;
    end else begin
      if (!run || last) cnt <= '0;
      else              cnt <= cnt + W'(1);
      q_p <= run & ({1'b0, cnt} < half);
    end
  end

  // For odd n q_n is q_p delayed half a cycle, trimming the high phase by
  // half a cycle for exact 50% duty. For even n it is held high so the AND
  // passes q_p straight through; the select is sampled on the falling edge,
  // when q_p is guaranteed low after a divisor change, so no mux glitch.
  always_ff @(negedge clk_in or negedge rst) begin
    if (!rst) q_n <= 1'b0;
    else      q_n <= q_p | ~n[0];
  end

  assign clk_out = q_p & q_n;

endmodule
`default_nettype wire

// File: rtl/prog_clk_div.sv
`default_nettype none
// ============================================================================
// Module  : prog_clk_div
// Purpose : Programmable clock divider with a valid/ready divisor interface.
//           A new divisor is held pending and applied at the next period
//           boundary (or at once when stopped). Divisors 0/1 become 2 and
//           set a sticky error flag.
// Ports   : clk_in  - source clock
//           rst     - asynchronous active-low reset
//           en      - run request; dropping it stops at end of period
//           cfg_vld - new divisor offered
//           cfg_div - offered divisor
//           cfg_rdy - no divisor pending
//           clk_out - divided clock
//           tick    - last cycle of each output period
//           cfg_err - sticky illegal-divisor flag
// Revision: 1.0 - initial release
// ============================================================================
module prog_clk_div
  import prog_clk_div_pkg::*;
#(
  parameter int W       = DIV_W_DEF,
  parameter int DEF_DIV = DEF_DIV_DEF
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         en,
  input  logic         cfg_vld,
  input  logic [W-1:0] cfg_div,
  output logic         cfg_rdy,
  output logic         clk_out,
  output logic         tick,
  output logic         cfg_err
);

  logic [W-1:0] div;
  logic [W-1:0] pend_div;
  logic         pend_vld;
  logic         running;
  logic         accept;
  logic         apply;
  logic         legal;

  assign cfg_rdy = ~pend_vld;
  assign accept  = cfg_vld & ~pend_vld;
  // tick marks the period boundary; when stopped any edge is a boundary
  assign apply   = pend_vld & (~running | tick);
  assign legal   = (cfg_div >= W'(MIN_DIV));

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      div      <= W'(DEF_DIV);
      pend_div <= W'(MIN_DIV);
      pend_vld <= 1'b0;
      running  <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      // apply and accept are exclusive: accept needs no pending value
      if (apply) begin
        div      <= pend_div;
        pend_vld <= 1'b0;
      end else if (accept) begin
        pend_vld <= 1'b1;
        pend_div <= legal ? cfg_div : W'(MIN_DIV);
        if (!legal) cfg_err <= 1'b1;
      end
      // en is only honoured at a period boundary or while stopped
      if (!running || tick) running <= en;
    end
  end

  clk_div_phase #(
    .W (W)
  ) u_phase (
    .clk_in  (clk_in),
    .rst     (rst),
    .run     (running),
    .n       (div),
    .clk_out (clk_out),
    .tick    (tick)
  );

endmodule
`default_nettype wire

// File: tb/tb_prog_clk_div.sv
`default_nettype none
// ============================================================================
// Module  : tb_prog_clk_div
// Purpose : Self-checking bench for prog_clk_div. A period-level reference
//           model predicts the output waveform half-cycle by half-cycle.
// Revision: 1.0 - initial release
// ============================================================================
module tb_prog_clk_div;

  logic       clk_in;
  logic       rst;
  logic       en;
  logic       cfg_vld;
  logic [7:0] cfg_div;
  logic       cfg_rdy;
  logic       clk_out;
  logic       tick;
  logic       cfg_err;

  int n_asrt;
  int n_fail;

  // reference model state: period length, position within period
  bit m_run;
  int m_n;
  int m_pos;
  bit m_pend;
  int m_pend_val;
  bit m_err;
  int cyc;

  prog_clk_div #(.W(8), .DEF_DIV(5)) dut (
    .clk_in  (clk_in),
    .rst     (rst),
    .en      (en),
    .cfg_vld (cfg_vld),
    .cfg_div (cfg_div),
    .cfg_rdy (cfg_rdy),
    .clk_out (clk_out),
    .tick    (tick),
    .cfg_err (cfg_err)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Expected divided clock: each period opens with one low cycle, then a
  // high phase of exactly N half-cycles (odd N starts half a cycle late).
  function automatic bit wave(input int n, input int pos, input bit second);
    if (pos == 0) return 1'b0;
    if (n % 2 == 0) return (pos <= n / 2);
    if (pos == 1) return second;
    return (pos <= (n + 1) / 2);
  endfunction

  task automatic check(input string tag, input logic got, input logic exp);
    n_asrt++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_n = 5; m_pos = 0; m_pend = 0; m_pend_val = 0; m_err = 0;
  endtask

  task automatic model_edge(input bit e, input bit v, input int d);
    bit bnd;
    bnd = m_run && (m_pos == m_n - 1);
    if (m_pend && (!m_run || bnd)) begin
      m_n    = m_pend_val;
      m_pend = 0;
    end else if (v && !m_pend) begin
      m_pend     = 1;
      m_pend_val = (d < 2) ? 2 : d;
      if (d < 2) m_err = 1;
    end
    if (!m_run || bnd) begin
      m_run = e;
      m_pos = 0;
    end else begin
      m_pos++;
    end
  endtask

  // One clk_in cycle: drive, clock, check both halves of the output
  task automatic step(input bit e, input bit v, input int d);
    en      = e;
    cfg_vld = v;
    cfg_div = 8'(d);
    @(posedge clk_in);
    cyc++;
    model_edge(e, v, d);
    #1;
    check("tick",    tick,    m_run && (m_pos == m_n - 1));
    check("cfg_rdy", cfg_rdy, !m_pend);
    check("cfg_err", cfg_err, m_err);
    check("clk_hi_half", clk_out, m_run ? wave(m_n, m_pos, 1'b0) : 1'b0);
    @(negedge clk_in);
    #1;
    check("clk_lo_half", clk_out, m_run ? wave(m_n, m_pos, 1'b1) : 1'b0);
  endtask

  initial begin
    n_asrt = 0; n_fail = 0; cyc = 0;
    rst = 1'b0; en = 1'b0; cfg_vld = 1'b0; cfg_div = 8'd0;
    model_reset();

    // reset state
    repeat (2) @(posedge clk_in);
    #1;
    check("rst_clk_out", clk_out, 1'b0);
    check("rst_tick",    tick,    1'b0);
    check("rst_cfg_rdy", cfg_rdy, 1'b1);
    check("rst_cfg_err", cfg_err, 1'b0);
    @(negedge clk_in);
    rst = 1'b1;
    #1;

    // default N=5 free-running
    repeat (22) step(1, 0, 0);

    // divisor 4 offered mid-period
    for (int k = 0; k < 10 && m_pos != 2; k++) step(1, 0, 0);
    step(1, 1, 4);
    repeat (20) step(1, 0, 0);

    // illegal divisor 1 becomes 2 and raises the sticky flag
    step(1, 1, 1);
    repeat (12) step(1, 0, 0);
    check("err_sticky", cfg_err, 1'b1);

    // N=7, drop en at cnt=1, then restart
    step(1, 1, 7);
    for (int k = 0; k < 20 && !(m_n == 7 && m_pos == 1); k++) step(1, 0, 0);
    repeat (20) step(0, 0, 0);
    repeat (20) step(1, 0, 0);

    // back-to-back offers: 9 must be dropped while 6 is pending
    step(1, 1, 6);
    step(1, 1, 9);
    repeat (30) step(1, 0, 0);

    // randomized traffic, including illegal divisors and en gaps
    for (int k = 0; k < 600; k++)
      step($urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 12));

    // async reset in the middle of a high phase
    for (int k = 0; k < 40 && !(m_run && wave(m_n, m_pos, 1'b1)); k++) step(1, 0, 0);
    check("pre_rst_high", clk_out, 1'b1);
    rst = 1'b0;
    #1;
    check("async_rst_clk", clk_out, 1'b0);
    check("async_rst_err", cfg_err, 1'b0);
    check("async_rst_rdy", cfg_rdy, 1'b1);
    model_reset();
    @(posedge clk_in);
    @(negedge clk_in);
    rst = 1'b1;
    #1;
    repeat (22) step(1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
